// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: nop encoding, reset PC and fetch FSM encoding.
package simplerisc_pkg;

  localparam logic [31:0] SR_NOP_INST = 32'h6800_0000;
  localparam logic [31:0] SR_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  // Sequential PC step; 32-bit arithmetic wraps 0xFFFF_FFFC to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory port between the fetch unit (master) and memory (slave).
// Handshake: the master raises imemReq with imemAddr and keeps both stable
// until a cycle in which the slave asserts imemValid with imemData; that
// cycle completes the transfer (imemValid may come in the request cycle).
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        imemValid;

  modport master (output imemReq, output imemAddr, input imemData, input imemValid);
  modport slave  (input imemReq, input imemAddr, output imemData, output imemValid);
endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched {pc, inst} while the OF stage stalls.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Next entry: clear beats load, load beats drain.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      inst_d  = inst_in;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Entry register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign inst  = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// SimpleRISC IF stage: PC, fetch FSM (FETCH/HOLD/DROP) and the IF/OF latch.
module fetch_unit
  import simplerisc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = SR_RESET_PC,
  parameter logic [31:0] NOP_INST = SR_NOP_INST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         branchPC,
  input  logic                isBranchTaken,
  input  logic                stall,
  fetch_unit_if.master        imem,
  output logic [31:0]         pc_OF,
  output logic [31:0]         inst_OF,
  output logic                valid_OF,
  output logic                flush,
  output fetch_state_e        state_dbg
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;  // address still owed a response in DROP
  logic [31:0]  pc_of_q, pc_of_d;
  logic [31:0]  inst_of_q, inst_of_d;
  logic         valid_of_q, valid_of_d;

  logic         skid_load, skid_drain, skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_pc, skid_inst;
  logic         imem_req;
  logic [31:0]  imem_addr;

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (skid_clear),
    .pc_in   (pc_q),
    .inst_in (imem.imemData),
    .valid   (skid_valid),
    .pc      (skid_pc),
    .inst    (skid_inst)
  );

  // Next state, PC, IF/OF latch and memory request; a taken branch overrides stall.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    pc_of_d     = pc_of_q;
    inst_of_d   = inst_of_q;
    valid_of_d  = valid_of_q;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_clear  = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc_q;

    if (isBranchTaken) begin
      pc_d       = branchPC;
      pc_of_d    = '0;
      inst_of_d  = NOP_INST;
      valid_of_d = 1'b0;
      skid_clear = 1'b1;
    end

    case (state_q)
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        if (isBranchTaken) begin
          // An in-flight request must still be answered before refetching.
          if (!imem.imemValid) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem.imemValid) begin
          pc_d = pc_plus4(pc_q);
          if (!stall) begin
            pc_of_d    = pc_q;
            inst_of_d  = imem.imemData;
            valid_of_d = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end else if (!stall) begin
          inst_of_d  = NOP_INST;
          valid_of_d = 1'b0;
        end
      end
      HOLD: begin
        if (isBranchTaken) begin
          state_d = FETCH;
        end else if (!stall) begin
          pc_of_d    = skid_pc;
          inst_of_d  = skid_inst;
          valid_of_d = skid_valid;
          skid_drain = 1'b1;
          state_d    = FETCH;
        end
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        // A newer branch only retargets the PC; leave once the stale response lands.
        if (imem.imemValid) begin
          state_d = FETCH;
        end
        if (!isBranchTaken && !stall) begin
          inst_of_d  = NOP_INST;
          valid_of_d = 1'b0;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State, PC and IF/OF latch registers; reset wins over branch and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      pc_of_q     <= '0;
      inst_of_q   <= NOP_INST;
      valid_of_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      pc_of_q     <= pc_of_d;
      inst_of_q   <= inst_of_d;
      valid_of_q  <= valid_of_d;
    end
  end

  assign imem.imemReq  = imem_req;
  assign imem.imemAddr = imem_addr;
  assign pc_OF         = pc_of_q;
  assign inst_OF       = inst_of_q;
  assign valid_OF      = valid_of_q;
  assign flush         = isBranchTaken;
  assign state_dbg     = state_q;

endmodule
